matrix_multiplier: RTL
======================

Name: matrix_multiplier

Overview:
- Responder side of the sequence multiplier's multiplier handshake.
- Accepts two complex 2x2 fixed-point matrices on a one-cycle ready strobe and computes result = a × b.
- Pulses done once the product is stable.
- Uses one time-multiplexed complex multiply-accumulate datapath, 8 compute cycles per product, instead of 8 parallel complex multipliers.

Parameters:
- NUMERIC_BITS, 19: width of each signed real/imag component.
- FRAC_BITS, 17: fractional bits of the fixed-point format (Q2.17 by default; range [-2, 2)).
- ACC_GUARD_BITS, 2: extra accumulator bits above 2×NUMERIC_BITS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a  in  signed [NUMERIC_BITS-1:0] [0:1][0:1][0:1]  left operand, indexed [row][col][re=0/im=1].
- b  in  signed [NUMERIC_BITS-1:0] [0:1][0:1][0:1]  right operand, same indexing.
- ready  in  1  start strobe; sampled only in IDLE.
- done  out  1  one-cycle pulse: result valid.
- result  out  signed [NUMERIC_BITS-1:0] [0:1][0:1][0:1]  product; held until the next completed multiply.
- busy  out  1  high in MULT and DONE states.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, done=0, busy=0, all result entries=0, step counter=0, accumulator=0.
- States: IDLE, MULT, DONE.
- IDLE:
  - On a rising edge with ready=1: latch a and b into operand registers, counter=0, clear accumulator, go to MULT.
  - The initiator may change a/b after this edge.
- MULT: step k=0..7.
  - Output entry (i,j) = (k[2], k[1]); term index t = k[0].
  - Compute the complex product A[i][t] × B[t][j] as four real multiplies: re = ar·br − ai·bi, im = ar·bi + ai·br.
  - Accumulate at full precision (2·NUMERIC_BITS + ACC_GUARD_BITS).
  - When t=1: scale and write result[i][j], then clear the accumulator.
  - After k=7, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE, with done=0 and busy=0.
- Latency: ready sampled at edge E; done high in the cycle following edge E+9. The next ready can be accepted at edge E+10.
- Scaling:
  - Arithmetic shift right by FRAC_BITS (floor).
  - Then saturate to [−2^(NUMERIC_BITS−1), 2^(NUMERIC_BITS−1)−1], independently per real/imag component.
- result entries update progressively during MULT. Consumers read result only on or after done. Entries not yet rewritten keep their previous product.
- ready while busy: ignored, no queuing. A ready still high on return to IDLE is accepted as a new request.
- Reset mid-operation: computation aborted; no done pulse; result cleared to 0.
- Operands equal to −2^(NUMERIC_BITS−1) are legal; overflow is handled by saturation only, never by wrap-around.

Optional Feature:
- MATRIX_MULTIPLIER_ROUND_EN defined: add 2^(FRAC_BITS−1) to the accumulator before the shift (round half up), then saturate.
- Not defined: plain floor truncation.
- Latency is identical in both builds.

Decomposition:
- Shared package quantum_pkg contains:
  - NUMERIC_BITS and FRAC_BITS constants.
  - RE=0 and IM=1 index constants.
  - ONE_FX = 2^FRAC_BITS.
  - typedef cplx_t (re/im pair) and typedef cplx_mtx_t (2x2 of cplx_t).
  - A saturate function.
- One natural sub-module: complex_mac, a combinational complex multiply plus accumulator add, instantiated once.
- The FSM, counter, operand latches and result registers stay in matrix_multiplier.

Test Plan:
- Identity × H, with H entries all real ±92682 (1/√2): after ready, done is asserted at exactly edge E+9 and result equals H bit-exact.
- H × H: result re = {131072, 0; 0, 131072}, all im = 0. Truncation gives 131072 on the diagonal (remainder 37064); the ROUND_EN build gives the same.
- S × S, with S = diag(1, i) i.e. a[1][1][IM]=131072: result = diag(131072, −131072), all imaginary parts 0.
- diag(1.5, 1.5) squared (196608 each): diagonal saturates to 262143; off-diagonal 0. A −2.0×−2.0 diagonal also saturates to 262143 with no wrap.
- Rounding: a[0][0]=1 raw, b[0][0]=65536, all other entries 0:
  - Truncate build: result[0][0][RE]=0.
  - ROUND_EN build: result[0][0][RE]=1.
  - With a[0][0]=−1 raw: truncate gives −1, rounding gives 0.
- Protocol:
  - ready re-pulsed at E+3 is ignored (a single done pulse).
  - reset=0 asserted at E+4 gives done=0, busy=0 and result all 0 immediately, with no later done.
  - ready held high continuously gives done pulses every 10 cycles.

Source files
------------

// File: rtl/quantum_pkg.sv
// quantum_pkg: shared fixed-point definitions for the complex matrix datapath.
//   NUMERIC_BITS / FRAC_BITS  : default Q2.17 component format
//   RE / IM                   : component index constants
//   ONE_FX                    : fixed-point 1.0
//   cplx_t / cplx_mtx_t       : complex scalar and 2x2 complex matrix
//   mm_state_t                : matrix_multiplier FSM states
//   saturate()                : clamp a wide signed value to a signed width
package quantum_pkg;

    localparam int NUMERIC_BITS = 19;
    localparam int FRAC_BITS    = 17;
    localparam int RE           = 0;
    localparam int IM           = 1;
    localparam int ONE_FX       = 1 << FRAC_BITS;

    typedef struct packed {
        logic signed [NUMERIC_BITS-1:0] re;
        logic signed [NUMERIC_BITS-1:0] im;
    } cplx_t;

    typedef cplx_t [0:1][0:1] cplx_mtx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DONE = 2'd2
    } mm_state_t;

    // Clamp x to [-2^(width-1), 2^(width-1)-1]; caller keeps the low width bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] x,
                                                    input int unsigned        width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (x > max_v) return max_v;
        if (x < min_v) return min_v;
        return x;
    endfunction

endpackage

// File: rtl/complex_mac.sv
// complex_mac: combinational complex multiply plus accumulate.
//   ar, ai   : left operand real/imag
//   br, bi   : right operand real/imag
//   acc_re/im: running accumulator
//   sum_re/im: acc + (ar + j*ai) * (br + j*bi), full precision
module complex_mac
    import quantum_pkg::*;
#(
    parameter int DATA_W = quantum_pkg::NUMERIC_BITS,
    parameter int ACC_W  = 2 * quantum_pkg::NUMERIC_BITS + 2
) (
    input  logic signed [DATA_W-1:0] ar,
    input  logic signed [DATA_W-1:0] ai,
    input  logic signed [DATA_W-1:0] br,
    input  logic signed [DATA_W-1:0] bi,
    input  logic signed [ACC_W-1:0]  acc_re,
    input  logic signed [ACC_W-1:0]  acc_im,
    output logic signed [ACC_W-1:0]  sum_re,
    output logic signed [ACC_W-1:0]  sum_im
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;

    assign p_rr = PW'(ar) * PW'(br);
    assign p_ii = PW'(ai) * PW'(bi);
    assign p_ri = PW'(ar) * PW'(bi);
    assign p_ir = PW'(ai) * PW'(br);

    assign sum_re = acc_re + ACC_W'(p_rr) - ACC_W'(p_ii);
    assign sum_im = acc_im + ACC_W'(p_ri) + ACC_W'(p_ir);

endmodule

// File: rtl/matrix_multiplier.sv
// matrix_multiplier: 2x2 complex fixed-point matrix product, result = a x b,
// using a single time-multiplexed complex MAC (8 steps per product).
//   clk, reset(active-low async)
//   a, b   : operands [row][col][re/im], latched when ready is seen in IDLE
//   ready  : start strobe, ignored while busy
//   done   : one-cycle pulse, result complete
//   result : product, entries written progressively, held until overwritten
//   busy   : high while a product is in flight
// Build option: define MATRIX_MULTIPLIER_ROUND_EN for round-half-up scaling;
// otherwise the accumulator is floor-truncated. Latency is the same either way.
module matrix_multiplier
    import quantum_pkg::*;
#(
    parameter int NUMERIC_BITS   = quantum_pkg::NUMERIC_BITS,
    parameter int FRAC_BITS      = quantum_pkg::FRAC_BITS,
    parameter int ACC_GUARD_BITS = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [0:1][0:1][0:1][NUMERIC_BITS-1:0]    a,
    input  logic [0:1][0:1][0:1][NUMERIC_BITS-1:0]    b,
    input  logic                                      ready,
    output logic                                      done,
    output logic [0:1][0:1][0:1][NUMERIC_BITS-1:0]    result,
    output logic                                      busy
);

    localparam int ACC_W = 2 * NUMERIC_BITS + ACC_GUARD_BITS;

    mm_state_t                                state;
    logic [2:0]                               k;
    logic [0:1][0:1][0:1][NUMERIC_BITS-1:0]   a_q, b_q;
    logic signed [ACC_W-1:0]                  acc_re, acc_im;
    logic signed [ACC_W-1:0]                  sum_re, sum_im;
    logic signed [NUMERIC_BITS-1:0]           ar, ai, br, bi;

    // Step k: output entry (i,j) = (k[2],k[1]), inner term t = k[0].
    assign ar = a_q[k[2]][k[0]][RE];
    assign ai = a_q[k[2]][k[0]][IM];
    assign br = b_q[k[0]][k[1]][RE];
    assign bi = b_q[k[0]][k[1]][IM];

    complex_mac #(
        .DATA_W (NUMERIC_BITS),
        .ACC_W  (ACC_W)
    ) u_mac (
        .ar     (ar),
        .ai     (ai),
        .br     (br),
        .bi     (bi),
        .acc_re (acc_re),
        .acc_im (acc_im),
        .sum_re (sum_re),
        .sum_im (sum_im)
    );

    // One extra bit so the rounding offset can never wrap the accumulator.
    function automatic logic [NUMERIC_BITS-1:0] scale(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] x;
        logic signed [63:0]    s;
        x = (ACC_W + 1)'(v);
`ifdef MATRIX_MULTIPLIER_ROUND_EN
        x = x + ((ACC_W + 1)'(1) <<< (FRAC_BITS - 1));
`endif
        x = x >>> FRAC_BITS;
        s = saturate(64'(x), NUMERIC_BITS);
        return s[NUMERIC_BITS-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            done   <= 1'b0;
            busy   <= 1'b0;
            result <= '0;
            k      <= '0;
            acc_re <= '0;
            acc_im <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ready) begin
                        a_q    <= a;
                        b_q    <= b;
                        k      <= '0;
                        acc_re <= '0;
                        acc_im <= '0;
                        busy   <= 1'b1;
                        state  <= MULT;
                    end
                end
                MULT: begin
                    if (k[0]) begin
                        // Second term of the dot product: entry complete.
                        result[k[2]][k[1]][RE] <= scale(sum_re);
                        result[k[2]][k[1]][IM] <= scale(sum_im);
                        acc_re <= '0;
                        acc_im <= '0;
                    end else begin
                        acc_re <= sum_re;
                        acc_im <= sum_im;
                    end
                    k <= k + 3'd1;
                    if (k == 3'd7) state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
